// File: rtl/letc_core_pkg.sv
`default_nettype none
// letc_core_pkg: shared LETC core types (sizes, addresses, data words, arbiter states).
// Rev 1.0
package letc_core_pkg;

  localparam int PADDR_W = 34;
  localparam int WORD_W  = 32;
  localparam int SIZE_W  = 2;

  typedef logic [PADDR_W-1:0] paddr_t;
  typedef logic [WORD_W-1:0]  word_t;

  typedef enum logic [SIZE_W-1:0] {
    SIZE_BYTE     = 2'b00,
    SIZE_HALFWORD = 2'b01,
    SIZE_WORD     = 2'b10
  } size_e;

  typedef enum logic {
    LIMP_ARB_IDLE    = 1'b0,
    LIMP_ARB_GRANTED = 1'b1
  } limp_arb_state_e;

endpackage
`default_nettype wire

// File: rtl/letc_core_rr_picker.sv
`default_nettype none
// letc_core_rr_picker: combinational round-robin winner search starting at ptr.
// Rev 1.0
module letc_core_rr_picker
  import letc_core_pkg::*;
#(
  parameter  int NUM_REQUESTERS = 3,
  localparam int IDX_W          = $clog2(NUM_REQUESTERS)
) (
  input  logic [NUM_REQUESTERS-1:0] req,
  input  logic [IDX_W-1:0]          ptr,
  output logic [IDX_W-1:0]          winner,
  output logic                      any_valid
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Scan from the farthest offset down so the offset closest to ptr is the last writer.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int off = NUM_REQUESTERS - 1; off >= 0; off--) begin
      cand     = (int'(ptr) + off) % NUM_REQUESTERS;
      cand_idx = IDX_W'(cand);
      if (req[cand_idx]) begin
        winner    = cand_idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/letc_core_limp_arbiter.sv
`default_nettype none
// letc_core_limp_arbiter: round-robin merge of LIMP requesters onto the AXI FSM port.
// Rev 1.0
module letc_core_limp_arbiter
  import letc_core_pkg::*;
#(
  parameter  int NUM_REQUESTERS = 3,
  localparam int IDX_W          = $clog2(NUM_REQUESTERS)
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic [NUM_REQUESTERS-1:0]              i_req_valid,
  output logic [NUM_REQUESTERS-1:0]              o_req_ready,
  input  logic [NUM_REQUESTERS-1:0]              i_req_wen_nren,
  input  logic [NUM_REQUESTERS-1:0][SIZE_W-1:0]  i_req_size,
  input  logic [NUM_REQUESTERS-1:0][PADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQUESTERS-1:0][WORD_W-1:0]  i_req_wdata,
  output logic [NUM_REQUESTERS-1:0][WORD_W-1:0]  o_req_rdata,
  output logic                                   o_valid,
  input  logic                                   i_ready,
  output logic                                   o_wen_nren,
  output size_e                                  o_size,
  output paddr_t                                 o_addr,
  output word_t                                  o_wdata,
  input  word_t                                  i_rdata
);

  limp_arb_state_e  state;
  limp_arb_state_e  state_next;
  logic [IDX_W-1:0] g;
  logic [IDX_W-1:0] p;
  logic [IDX_W-1:0] winner;
  logic             any_valid;
  logic             stray_ready;

  letc_core_rr_picker #(
    .NUM_REQUESTERS(NUM_REQUESTERS)
  ) u_picker (
    .req      (i_req_valid),
    .ptr      (p),
    .winner   (winner),
    .any_valid(any_valid)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= LIMP_ARB_IDLE;
      g     <= '0;
      p     <= '0;
    end else begin
      state <= state_next;
      if (state == LIMP_ARB_IDLE && any_valid) begin
        g <= winner;
      end
      // Pointer only advances on completion, giving bounded wait of N-1 transactions.
      if (state == LIMP_ARB_GRANTED && i_ready) begin
        p <= (int'(g) == NUM_REQUESTERS - 1) ? '0 : g + IDX_W'(1);
      end
    end
  end

  always_comb begin
    state_next  = state;
    o_valid     = 1'b0;
    o_wen_nren  = 1'b0;
    o_size      = SIZE_BYTE;
    o_addr      = '0;
    o_wdata     = '0;
    o_req_ready = '0;
    o_req_rdata = '0;
    case (state)
      LIMP_ARB_IDLE: begin
        if (any_valid) begin
          state_next = LIMP_ARB_GRANTED;
        end
      end
      LIMP_ARB_GRANTED: begin
        o_valid    = 1'b1;
        o_wen_nren = i_req_wen_nren[g];
        o_size     = size_e'(i_req_size[g]);
        o_addr     = i_req_addr[g];
        o_wdata    = i_req_wdata[g];
        if (i_ready) begin
          o_req_ready[g] = 1'b1;
          o_req_rdata[g] = i_rdata;
          state_next     = LIMP_ARB_IDLE;
        end
      end
    endcase
  end

  // A completion from downstream with nothing granted is a protocol error on the AXI side.
  assign stray_ready = i_ready && (state == LIMP_ARB_IDLE);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      assert ($onehot0(o_req_ready));
      assert (!(|o_req_ready) || o_valid);
      assert (int'(g) < NUM_REQUESTERS);
      if (state == LIMP_ARB_GRANTED) begin
        assert (i_req_valid[g]);
      end
    end
  end

  assert property (@(posedge i_clk) disable iff (i_rst)
    (o_valid && !i_ready) |=> $stable({o_wen_nren, o_size, o_addr, o_wdata}));

  cover property (@(posedge i_clk) stray_ready);

endmodule
`default_nettype wire

// File: tb/tb_letc_core_limp_arbiter.sv
`default_nettype none
// tb_letc_core_limp_arbiter: scoreboard bench for the LIMP round-robin arbiter.
module tb_letc_core_limp_arbiter;
  import letc_core_pkg::*;

  localparam int N = 3;

  logic                          clk = 1'b0;
  logic                          rst = 1'b1;
  logic [N-1:0]                  req_valid;
  logic [N-1:0]                  req_ready;
  logic [N-1:0]                  req_wen;
  logic [N-1:0][SIZE_W-1:0]      req_size;
  logic [N-1:0][PADDR_W-1:0]     req_addr;
  logic [N-1:0][WORD_W-1:0]      req_wdata;
  logic [N-1:0][WORD_W-1:0]      req_rdata;
  logic                          valid;
  logic                          ready;
  logic                          wen;
  size_e                         size;
  paddr_t                        addr;
  word_t                         wdata;
  word_t                         rdata;

  letc_core_limp_arbiter #(.NUM_REQUESTERS(N)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_wen_nren(req_wen),
    .i_req_size    (req_size),
    .i_req_addr    (req_addr),
    .i_req_wdata   (req_wdata),
    .o_req_rdata   (req_rdata),
    .o_valid       (valid),
    .i_ready       (ready),
    .o_wen_nren    (wen),
    .o_size        (size),
    .o_addr        (addr),
    .o_wdata       (wdata),
    .i_rdata       (rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    bit          contended;
    logic        wen;
    logic [1:0]  size;
    paddr_t      addr;
    word_t       wdata;
  } grant_t;

  typedef struct {
    int    idx;
    word_t rdata;
  } cpl_t;

  grant_t gq[$];
  cpl_t   cq[$];
  word_t  rdq[$];
  int     pend[N];
  bit     done_f[N];
  int     resp_lat = 1;
  int     vcnt = 0;
  int     checks = 0;
  int     errors = 0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endfunction

  task automatic set_req(int k, logic w, logic [1:0] sz, paddr_t a, word_t d);
    req_wen[k]   = w;
    req_size[k]  = sz;
    req_addr[k]  = a;
    req_wdata[k] = d;
  endtask

  function automatic void expect_grant(int k, bit cont);
    grant_t e;
    e.idx       = k;
    e.contended = cont;
    e.wen       = req_wen[k];
    e.size      = req_size[k];
    e.addr      = req_addr[k];
    e.wdata     = req_wdata[k];
    gq.push_back(e);
  endfunction

  function automatic void expect_cpl(int k, word_t rd);
    cpl_t c;
    c.idx   = k;
    c.rdata = rd;
    cq.push_back(c);
    rdq.push_back(rd);
  endfunction

  // Requester and AXI-side models, driven just after the active edge.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < N; k++) begin
      if (done_f[k]) begin
        done_f[k] = 1'b0;
        if (pend[k] > 0) pend[k]--;
      end
      req_valid[k] = (pend[k] != 0);
    end
    if (ready) begin
      ready = 1'b0;
      vcnt  = 0;
    end else if (valid) begin
      vcnt++;
      if (vcnt >= resp_lat) begin
        ready = 1'b1;
        rdata = (rdq.size() > 0) ? rdq.pop_front() : '0;
      end
    end else begin
      vcnt = 0;
    end
  end

  // Monitor: pops expectations when the DUT presents a grant or completion.
  bit                     prev_valid = 1'b0;
  bit                     prev_ready = 1'b0;
  bit                     bubble_prev = 1'b0;
  grant_t                 cur;
  cpl_t                   cpl;
  logic [N-1:0][WORD_W-1:0] exp_rd;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid  = 1'b0;
      prev_ready  = 1'b0;
      bubble_prev = 1'b0;
    end else begin
      if (bubble_prev && gq.size() > 0 && gq[0].contended) chk("regrant_after_bubble", valid, 1'b1);
      bubble_prev = 1'b0;
      if (prev_ready) begin
        chk("idle_bubble", valid, 1'b0);
        bubble_prev = 1'b1;
      end
      if (valid && !prev_valid) begin
        if (gq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant actual_addr=0x%0h required=none", addr);
        end else begin
          cur = gq.pop_front();
          chk($sformatf("grant%0d_addr", cur.idx), addr, cur.addr);
          chk($sformatf("grant%0d_ctrl", cur.idx), {wen, size}, {cur.wen, cur.size});
          chk($sformatf("grant%0d_wdata", cur.idx), wdata, cur.wdata);
        end
      end else if (valid) begin
        chk("fields_stable", {wen, size, addr, wdata}, {cur.wen, cur.size, cur.addr, cur.wdata});
      end
      if (|req_ready) begin
        if (cq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready actual=0x%0h required=0", req_ready);
        end else begin
          cpl = cq.pop_front();
          exp_rd = '0;
          exp_rd[cpl.idx] = cpl.rdata;
          chk($sformatf("cpl%0d_ready", cpl.idx), req_ready, N'(1) << cpl.idx);
          chk($sformatf("cpl%0d_rdata", cpl.idx), req_rdata, exp_rd);
        end
        for (int k = 0; k < N; k++) if (req_ready[k]) done_f[k] = 1'b1;
      end
      prev_valid = valid;
      prev_ready = |req_ready;
    end
  end

  task automatic wait_idle(string name);
    int n;
    bit busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
      busy = valid || gq.size() != 0 || cq.size() != 0 || (pend[0] + pend[1] + pend[2]) != 0;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=busy required=idle", name);
      gq.delete();
      cq.delete();
      rdq.delete();
      for (int k = 0; k < N; k++) pend[k] = 0;
    end
  endtask

  initial begin
    int n;
    for (int k = 0; k < N; k++) begin
      pend[k]   = 0;
      done_f[k] = 1'b0;
      set_req(k, 1'b0, SIZE_BYTE, '0, '0);
    end
    req_valid = '0;
    ready     = 1'b0;
    rdata     = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", valid, 1'b0);
    chk("rst_ready", req_ready, 3'b000);
    chk("rst_rdata", req_rdata, '0);
    chk("rst_addr", addr, '0);
    chk("rst_ptr", dut.p, 2'd0);

    // Single read on requester 1
    set_req(1, 1'b0, SIZE_WORD, 34'h0_0000_1004, '0);
    expect_grant(1, 1'b0);
    expect_cpl(1, 32'hDEADBEEF);
    resp_lat = 1;
    @(posedge clk);
    #2 pend[1] = 1; req_valid[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("s1_latency_valid", valid, 1'b1);
    chk("s1_addr", addr, 34'h0_0000_1004);
    chk("s1_ready_same_cycle", req_ready, 3'b010);
    chk("s1_rdata1", req_rdata[1], 32'hDEADBEEF);
    wait_idle("s1");

    // Wrap: pointer sits at 2, requests on 0 and 2
    set_req(0, 1'b0, SIZE_BYTE, 34'h0_0000_2000, '0);
    set_req(2, 1'b0, SIZE_WORD, 34'h3_0000_0010, '0);
    expect_grant(2, 1'b0);
    expect_grant(0, 1'b1);
    expect_cpl(2, 32'h2222_0002);
    expect_cpl(0, 32'h0000_00A5);
    resp_lat = 2;
    @(posedge clk);
    #2 pend[0] = 1; pend[2] = 1; req_valid = 3'b101;
    wait_idle("wrap");

    // All three valid from reset, two-cycle transactions
    @(posedge clk);
    #2 rst = 1'b1;
    set_req(0, 1'b0, SIZE_WORD, 34'h0_0000_0100, '0);
    set_req(1, 1'b1, SIZE_WORD, 34'h1_0000_0200, 32'h1111_1111);
    set_req(2, 1'b0, SIZE_BYTE, 34'h2_0000_0303, '0);
    expect_grant(0, 1'b0);
    expect_grant(1, 1'b1);
    expect_grant(2, 1'b1);
    expect_grant(0, 1'b1);
    expect_cpl(0, 32'hA000_0000);
    expect_cpl(1, 32'hA111_1111);
    expect_cpl(2, 32'hA222_2222);
    expect_cpl(0, 32'hA000_0001);
    pend[0] = 2; pend[1] = 1; pend[2] = 1;
    req_valid = 3'b111;
    resp_lat = 2;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    wait_idle("all3");

    // Field stability while requester 0 joins mid-transaction
    set_req(2, 1'b1, SIZE_HALFWORD, 34'h2_0000_0008, 32'h0000_ABCD);
    set_req(0, 1'b0, SIZE_WORD, 34'h0_0000_0400, '0);
    expect_grant(2, 1'b0);
    expect_grant(0, 1'b1);
    expect_cpl(2, 32'h0000_0000);
    expect_cpl(0, 32'h0400_0400);
    resp_lat = 4;
    @(posedge clk);
    #2 pend[2] = 1; req_valid[2] = 1'b1;
    repeat (3) @(posedge clk);
    #2 pend[0] = 1; req_valid[0] = 1'b1;
    wait_idle("stable");

    // Reset while granted (pointer is 1 here)
    set_req(2, 1'b0, SIZE_WORD, 34'h0_0000_0500, '0);
    expect_grant(2, 1'b0);
    resp_lat = 10;
    @(posedge clk);
    #2 pend[2] = 1; req_valid[2] = 1'b1;
    n = 0;
    while (!valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!valid) begin
      checks++;
      errors++;
      $display("FAIL rstgrant_wait actual=idle required=granted");
    end
    @(posedge clk);
    #2 rst = 1'b1;
    for (int k = 0; k < N; k++) pend[k] = 0;
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    chk("rstgrant_valid", valid, 1'b0);
    chk("rstgrant_ready", req_ready, 3'b000);
    chk("rstgrant_ptr", dut.p, 2'd0);
    @(posedge clk);
    #2 rst = 1'b0;

    // Requester 2 alone afterwards, re-granted after each bubble
    expect_grant(2, 1'b0);
    expect_grant(2, 1'b1);
    expect_cpl(2, 32'h5050_0001);
    expect_cpl(2, 32'h5050_0002);
    resp_lat = 1;
    @(posedge clk);
    #2 pend[2] = 2; req_valid[2] = 1'b1;
    wait_idle("post_rst");

    // Stray completion while idle
    @(posedge clk);
    #2 ready = 1'b1; rdata = 32'h1234_5678;
    @(negedge clk);
    chk("stray_no_ready", req_ready, 3'b000);
    chk("stray_flagged", dut.stray_ready, 1'b1);
    @(posedge clk);
    #2 ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
